// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU, its program loader and the bench.
package cpu_pkg;

    // Instruction opcodes (upper nibble of an instruction byte)
    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpOut = 4'h3;
    localparam logic [3:0] OpJmp = 4'h4;
    localparam logic [3:0] OpSta = 4'h5;

    // Loader framing defaults
    localparam logic [7:0]  SyncByteDefault = 8'hA5;
    localparam int unsigned RamAddrW        = 4;
    localparam int unsigned RamDepthDefault = 16;

    typedef enum logic [2:0] {
        StWaitSync,
        StGetLen,
        StGetData,
        StGetSum,
        StRun,
        StError
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
interface program_loader_if;
    import cpu_pkg::*;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                ram_we;
    logic [RamAddrW-1:0] ram_addr;
    logic [7:0]          ram_wdata;

    // Byte source / RAM side
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, ram_we, ram_addr, ram_wdata
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: a down-counter reloaded on every accepted byte and
// parked at its reload value while no frame is in progress.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,   // a frame is being received
    input  logic kick,     // a byte was accepted this cycle
    output logic expired   // this idle cycle is the last one allowed
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    // Reload on a byte or outside a frame, otherwise count down idle cycles
    always_comb begin
        count_d = count_q;
        if (!active || kick) begin
            count_d = LoadVal;
        end else if (count_q != '0) begin
            count_d = count_q - CntW'(1);
        end
        // An acceptance in the expiring cycle wins over the timeout
        expired = active && !kick && (count_q == '0);
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream (sync, length, payload, checksum), writes the
// payload into the program RAM and releases the CPU once the checksum matches.
module program_loader
    import cpu_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SyncByteDefault,
    parameter int unsigned RAM_DEPTH      = RamDepthDefault,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus,
    output logic             cpu_halt,
    output logic             cpu_restart,
    output logic             load_done,
    output logic             load_error
);

    localparam int unsigned LenW   = $clog2(RAM_DEPTH + 1);
    localparam logic [7:0]  MaxLen = 8'(RAM_DEPTH);

    loader_state_e       state_q, state_d;
    logic [LenW-1:0]     len_q, len_d;
    logic [LenW-1:0]     idx_q, idx_d;
    logic [7:0]          sum_q, sum_d;
    logic                ram_we_q, ram_we_d;
    logic [RamAddrW-1:0] addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                halt_q, halt_d;
    logic                restart_q, restart_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic            accept;
    logic            is_sync;
    logic            to_error;
    logic            frame_active;
    logic            timed_out;
    logic [LenW-1:0] idx_inc;

    // Never back-pressured, so every valid byte is a transfer
    assign accept       = bus.rx_valid;
    assign is_sync      = (bus.rx_data == SYNC_BYTE);
    assign idx_inc      = idx_q + LenW'(1);
    assign frame_active = (state_q == StGetLen) || (state_q == StGetData)
                       || (state_q == StGetSum);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .active  (frame_active),
        .kick    (accept),
        .expired (timed_out)
    );

    // Next-state and registered-output logic of the framing FSM
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        ram_we_d  = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        halt_d    = halt_q;
        restart_d = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        to_error  = 1'b0;

        unique case (state_q)
            StWaitSync: begin
                if (accept && is_sync) begin
                    state_d = StGetLen;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            StGetLen: begin
                if (accept) begin
                    if (bus.rx_data != 8'd0 && bus.rx_data <= MaxLen) begin
                        len_d   = LenW'(bus.rx_data);
                        state_d = StGetData;
                    end else begin
                        to_error = 1'b1;
                    end
                end else if (timed_out) begin
                    to_error = 1'b1;
                end
            end
            StGetData: begin
                // Sync bytes are ordinary payload here
                if (accept) begin
                    ram_we_d = 1'b1;
                    addr_d   = idx_q[RamAddrW-1:0];
                    wdata_d  = bus.rx_data;
                    idx_d    = idx_inc;
                    sum_d    = sum_q + bus.rx_data;
                    if (idx_inc == len_q) begin
                        state_d = StGetSum;
                    end
                end else if (timed_out) begin
                    to_error = 1'b1;
                end
            end
            StGetSum: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        state_d   = StRun;
                        restart_d = 1'b1;
                        halt_d    = 1'b0;
                        done_d    = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        to_error = 1'b1;
                    end
                end else if (timed_out) begin
                    to_error = 1'b1;
                end
            end
            StRun: begin
                // A new frame halts the CPU on the very edge the sync arrives
                if (accept && is_sync) begin
                    state_d = StGetLen;
                    halt_d  = 1'b1;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            StError: begin
                if (accept && is_sync) begin
                    state_d = StGetLen;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            default: begin
                state_d = StWaitSync;
                halt_d  = 1'b1;
            end
        endcase

        if (to_error) begin
            state_d = StError;
            err_d   = 1'b1;
            done_d  = 1'b0;
            halt_d  = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitSync;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            ram_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            halt_q    <= 1'b1;
            restart_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            ram_we_q  <= ram_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            halt_q    <= halt_d;
            restart_q <= restart_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.rx_ready  = 1'b1;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign cpu_halt      = halt_q;
    assign cpu_restart   = restart_q;
    assign load_done     = done_q;
    assign load_error    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad frames, length limits,
// resync from RUN, inter-byte timeout and mid-frame reset.
module tb_program_loader;
    import cpu_pkg::*;

    localparam int unsigned Timeout = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_halt, cpu_restart, load_done, load_error;

    program_loader_if bus_if ();

    program_loader #(
        .SYNC_BYTE      (8'hA5),
        .RAM_DEPTH      (16),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .cpu_halt    (cpu_halt),
        .cpu_restart (cpu_restart),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    // RAM model and pulse counters fed from the write port
    logic [7:0] mem [16];
    int wcount = 0;
    int rcount = 0;
    always @(posedge clk) begin
        if (bus_if.ram_we) begin
            mem[bus_if.ram_addr] <= bus_if.ram_wdata;
            wcount <= wcount + 1;
        end
        if (cpu_restart) rcount <= rcount + 1;
    end

    int n_pass  = 0;
    int n_total = 0;
    int base_w, base_r;

    // Payload of the reference frame; 8-bit sum = 0x1C
    logic [7:0] pay [7] = '{8'h16, 8'h30, 8'h26, 8'h57, 8'h17, 8'h41, 8'h01};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // One-cycle transfer; returns 1 time unit after the accepting edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;

        // Reset values
        idle(3);
        chk("rst_halt", cpu_halt, 1);
        chk("rst_restart", cpu_restart, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        chk("rst_we", bus_if.ram_we, 0);
        chk("rst_addr", bus_if.ram_addr, 0);
        chk("rst_wdata", bus_if.ram_wdata, 0);
        chk("rx_ready", bus_if.rx_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Stray bytes before sync are dropped
        base_w = wcount;
        send(8'h07);
        send(8'h01);
        idle(2);
        chk("stray_no_we", wcount - base_w, 0);

        // Good frame: writes land one cycle after each data byte
        base_w = wcount;
        base_r = rcount;
        send(8'hA5);
        send(8'h07);
        for (int i = 0; i < 7; i++) begin
            send(pay[i]);
            chk("a_we", bus_if.ram_we, 1);
            chk("a_addr", bus_if.ram_addr, i);
            chk("a_wdata", bus_if.ram_wdata, pay[i]);
        end
        chk("a_halt_before_sum", cpu_halt, 1);
        send(8'h1C);
        chk("a_restart", cpu_restart, 1);
        chk("a_halt", cpu_halt, 0);
        chk("a_done", load_done, 1);
        chk("a_err", load_error, 0);
        idle(1);
        chk("a_restart_one_cycle", cpu_restart, 0);
        idle(2);
        chk("a_wcount", wcount - base_w, 7);
        chk("a_rcount", rcount - base_r, 1);

        // Same frame with a wrong checksum, started from RUN
        base_r = rcount;
        send(8'hA5);
        chk("b_halt_on_sync", cpu_halt, 1);
        chk("b_done_cleared", load_done, 0);
        send(8'h07);
        for (int i = 0; i < 7; i++) send(pay[i]);
        send(8'h1D);
        chk("b_err", load_error, 1);
        chk("b_halt", cpu_halt, 1);
        chk("b_done", load_done, 0);
        idle(2);
        chk("b_no_restart", rcount - base_r, 0);

        // Length 0 and length 17 fail with no writes
        base_w = wcount;
        send(8'hA5);
        chk("len_sync_clears_err", load_error, 0);
        send(8'h00);
        chk("len0_err", load_error, 1);
        send(8'hA5);
        send(8'h11);
        chk("len17_err", load_error, 1);
        chk("len17_halt", cpu_halt, 1);
        idle(2);
        chk("len_no_we", wcount - base_w, 0);

        // Recovery with a two-byte frame; words past the length keep old data
        send(8'hA5);
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'h65);
        chk("rec_done", load_done, 1);
        chk("rec_err", load_error, 0);
        chk("rec_halt", cpu_halt, 0);
        idle(1);
        chk("rec_mem0", mem[0], 8'hAA);
        chk("rec_mem1", mem[1], 8'hBB);
        chk("rec_mem2_kept", mem[2], 8'h26);

        // Resync from RUN with a 0xFF payload
        send(8'hA5);
        chk("run_halt_on_sync", cpu_halt, 1);
        send(8'h01);
        send(8'hFF);
        chk("run_we", bus_if.ram_we, 1);
        chk("run_addr", bus_if.ram_addr, 0);
        chk("run_wdata", bus_if.ram_wdata, 8'hFF);
        send(8'hFF);
        chk("run_restart", cpu_restart, 1);
        chk("run_halt", cpu_halt, 0);

        // A stall one cycle short of the limit is tolerated
        send(8'hA5);
        send(8'h07);
        for (int i = 0; i < 3; i++) send(pay[i]);
        idle(Timeout - 1);
        chk("to49_no_err", load_error, 0);
        for (int i = 3; i < 7; i++) send(pay[i]);
        send(8'h1C);
        chk("to49_done", load_done, 1);

        // A full-length stall trips the timeout
        base_w = wcount;
        send(8'hA5);
        send(8'h07);
        for (int i = 0; i < 3; i++) send(pay[i]);
        idle(Timeout - 1);
        chk("to50_pre", load_error, 0);
        idle(1);
        chk("to50_err", load_error, 1);
        chk("to50_halt", cpu_halt, 1);
        send(pay[3]);
        idle(1);
        chk("to50_wcount", wcount - base_w, 3);

        // Reset while a write is pending
        base_w = wcount;
        send(8'hA5);
        send(8'h07);
        send(8'h16);
        send(8'h30);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", bus_if.ram_we, 0);
        chk("mid_rst_halt", cpu_halt, 1);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_err", load_error, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h07);
        send(8'h01);
        idle(2);
        chk("mid_rst_wcount", wcount - base_w, 1);
        send(8'hA5);
        send(8'h01);
        send(8'h33);
        send(8'h33);
        chk("mid_rst_done_after", load_done, 1);
        idle(1);
        chk("mid_rst_mem0", mem[0], 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
